// File: rtl/kgp_ctrl_fsm_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle control unit.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_e;

  // Instruction class resolved once in DECODE and held for the rest of the instruction.
  typedef enum logic [3:0] {
    CL_ALU,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_B,
    CL_BL,
    CL_JR,
    CL_NOP,
    CL_HALT,
    CL_ILL
  } instr_class_e;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [3:0] F_LD   = 4'h0;
  localparam logic [3:0] F_ST   = 4'h1;
  localparam logic [3:0] F_BZ   = 4'h2;
  localparam logic [3:0] F_BNZ  = 4'h3;
  localparam logic [3:0] F_BC   = 4'h4;
  localparam logic [3:0] F_BNC  = 4'h5;
  localparam logic [3:0] F_B    = 4'h0;
  localparam logic [3:0] F_BL   = 4'h1;
  localparam logic [3:0] F_JR   = 4'h2;
  localparam logic [3:0] F_NOP  = 4'h0;
  localparam logic [3:0] F_HALT = 4'h1;

  localparam logic [1:0] PC_SEL_INC = 2'd0;
  localparam logic [1:0] PC_SEL_REL = 2'd1;
  localparam logic [1:0] PC_SEL_ABS = 2'd2;
  localparam logic [1:0] PC_SEL_REG = 2'd3;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'h0;

  // Map the decoder fields onto an instruction class; unknown encodings become CL_ILL.
  function automatic instr_class_e classify(input logic [1:0] op, input logic [3:0] funct);
    instr_class_e c;
    c = CL_ILL;
    case (op)
      OP_ALU: c = CL_ALU;
      OP_MEM: begin
        case (funct)
          F_LD:                      c = CL_LD;
          F_ST:                      c = CL_ST;
          F_BZ, F_BNZ, F_BC, F_BNC:  c = CL_BR;
          default:                   c = CL_ILL;
        endcase
      end
      OP_JMP: begin
        case (funct)
          F_B:     c = CL_B;
          F_BL:    c = CL_BL;
          F_JR:    c = CL_JR;
          default: c = CL_ILL;
        endcase
      end
      default: begin
        case (funct)
          F_NOP:   c = CL_NOP;
          F_HALT:  c = CL_HALT;
          default: c = CL_ILL;
        endcase
      end
    endcase
    return c;
  endfunction

  // Condition of a conditional branch given its funct field and the ALU flags.
  function automatic logic branch_taken(input logic [3:0] funct, input logic z, input logic c);
    logic t;
    t = 1'b0;
    case (funct)
      F_BZ:    t = z;
      F_BNZ:   t = !z;
      F_BC:    t = c;
      F_BNC:   t = !c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/kgp_ctrl_fsm_if.sv
// Request/acknowledge port between the control unit and the unified memory.
interface kgp_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/kgp_ctrl_fsm_timer.sv
// Wait-cycle counter for one memory request; hit marks the last allowed cycle.
module kgp_mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [7:0] cnt;

  // cnt holds how many request cycles have already elapsed without an ack.
  assign hit = (cnt == 8'(LIMIT - 1));

  // Count request cycles; clearing wins so every new request starts at zero.
  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/kgp_ctrl_fsm.sv
// Multi-cycle sequencer: fetch, decode, execute, memory, writeback, plus status.
module kgp_ctrl_fsm
  import kgp_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op_code,
  input  logic [3:0]           function_code,
  input  logic                 flag_z,
  input  logic                 flag_c,
  kgp_ctrl_fsm_if.master       mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic [3:0]           alu_op,
  output logic                 alu_src,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     retired
);

  state_e       state;
  instr_class_e cls_q;
  logic [3:0]   funct_q;
  logic         req_c;
  logic         we_c;
  logic         addr_c;
  logic         retire_c;
  logic         in_req;
  logic         wait_hit;

  assign in_req       = (state == ST_FETCH) || (state == ST_MEM);
  assign mem.mem_req  = req_c;
  assign mem.mem_we   = we_c;
  assign mem.addr_sel = addr_c;

  kgp_mem_wait_timer #(.LIMIT(MEM_WAIT_MAX)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!in_req || mem.mem_ack),
    .en  (in_req),
    .hit (wait_hit)
  );

  // Datapath enables decoded from state and the held instruction class.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_INC;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_SEL_ALU;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    halted   = 1'b0;
    retire_c = 1'b0;
    case (state)
      ST_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_ALU: alu_op = funct_q;
          CL_LD, CL_ST: alu_src = 1'b1;
          CL_BR: begin
            pc_we    = branch_taken(funct_q, flag_z, flag_c);
            pc_sel   = PC_SEL_REL;
            retire_c = 1'b1;
          end
          CL_B: begin
            pc_we    = 1'b1;
            pc_sel   = PC_SEL_ABS;
            retire_c = 1'b1;
          end
          CL_BL: begin
            pc_we    = 1'b1;
            pc_sel   = PC_SEL_ABS;
            reg_we   = 1'b1;
            wb_sel   = WB_SEL_LINK;
            retire_c = 1'b1;
          end
          CL_JR: begin
            pc_we    = 1'b1;
            pc_sel   = PC_SEL_REG;
            retire_c = 1'b1;
          end
          CL_NOP, CL_HALT: retire_c = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        // Address comes from the ALU, so its operands stay selected for the whole request.
        req_c    = 1'b1;
        addr_c   = 1'b1;
        we_c     = (cls_q == CL_ST);
        alu_src  = 1'b1;
        retire_c = (cls_q == CL_ST) && mem.mem_ack;
      end
      ST_WB: begin
        reg_we   = 1'b1;
        retire_c = 1'b1;
        if (cls_q == CL_LD) begin
          wb_sel = WB_SEL_MEM;
        end else begin
          alu_op = funct_q;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // State sequencing, instruction capture and sticky status/counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cls_q   <= CL_NOP;
      funct_q <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      retired <= '0;
    end else begin
      if (retire_c) begin
        retired <= retired + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem.mem_ack) begin
            state <= ST_DECODE;
          end else if (wait_hit) begin
            bus_err <= 1'b1;
            state   <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          cls_q   <= classify(op_code, function_code);
          funct_q <= function_code;
          if (classify(op_code, function_code) == CL_ILL) begin
            illegal <= 1'b1;
            state   <= ST_FAULT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CL_ALU:       state <= ST_WB;
            CL_LD, CL_ST: state <= ST_MEM;
            CL_HALT:      state <= ST_HALT;
            default:      state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem.mem_ack) begin
            state <= (cls_q == CL_LD) ? ST_WB : ST_FETCH;
          end else if (wait_hit) begin
            bus_err <= 1'b1;
            state   <= ST_FAULT;
          end
        end
        ST_WB:   state <= ST_FETCH;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Directed bench for kgp_ctrl_fsm with a short memory timeout (MEM_WAIT_MAX=4).
module tb_kgp_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op_code;
  logic [3:0]  function_code;
  logic        flag_z;
  logic        flag_c;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        halted;
  logic        illegal;
  logic        bus_err;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  kgp_ctrl_fsm_if bus ();

  kgp_ctrl_fsm #(.MEM_WAIT_MAX(4), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op_code       (op_code),
    .function_code (function_code),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .mem           (bus),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .alu_op        (alu_op),
    .alu_src       (alu_src),
    .halted        (halted),
    .illegal       (illegal),
    .bus_err       (bus_err),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  // Expected control word: {ir_we,pc_we,pc_sel,mem_req,mem_we,addr_sel,reg_we,wb_sel,alu_op,alu_src,halted}
  function automatic logic [15:0] ctl(input logic ir, input logic pc, input logic [1:0] pcs,
                                      input logic req, input logic we, input logic as,
                                      input logic rw, input logic [1:0] wbs,
                                      input logic [3:0] aop, input logic asrc, input logic h);
    return {ir, pc, pcs, req, we, as, rw, wbs, aop, asrc, h};
  endfunction

  function automatic logic [15:0] obs_ctl();
    return {ir_we, pc_we, pc_sel, bus.mem_req, bus.mem_we, bus.addr_sel,
            reg_we, wb_sel, alu_op, alu_src, halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [3:0] fn, input logic ack);
    op_code       = op;
    function_code = fn;
    bus.mem_ack   = ack;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Fetch acked on its first cycle, then DECODE; returns positioned in EXEC.
  task automatic fetch(input string tag, input logic [1:0] op, input logic [3:0] fn);
    set_in(op, fn, 1'b1);
    check({tag, "_fetch"}, 32'(obs_ctl()), 32'(ctl(1,1,2'd0,1,0,0,0,2'd0,4'h0,0,0)));
    step();
    set_in(op, fn, 1'b0);
    check({tag, "_decode"}, 32'(obs_ctl()), 32'h0);
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_code = '0; function_code = '0;
    flag_z = 1'b0; flag_c = 1'b0; bus.mem_ack = 1'b0;

    // 1: reset state, ALU instruction with a 2-cycle fetch wait
    do_reset();
    check("rst_ctl", 32'(obs_ctl()), 32'h0);
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    go();
    set_in(2'b00, 4'h2, 1'b0);
    check("t1_fetch_w1", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,1,0,0,0,2'd0,4'h0,0,0)));
    step();
    check("t1_fetch_w2", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,1,0,0,0,2'd0,4'h0,0,0)));
    step();
    fetch("t1", 2'b00, 4'h2);
    check("t1_exec", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,0,2'd0,4'h2,0,0)));
    step();
    check("t1_wb", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,1,2'd0,4'h2,0,0)));
    check("t1_retired_pre", retired, 32'd0);
    step();
    check("t1_retired", retired, 32'd1);

    // 2: LD then ST, each acked on the first MEM cycle
    do_reset();
    go();
    fetch("t2_ld", 2'b01, 4'h0);
    check("t2_ld_exec", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,0,2'd0,4'h0,1,0)));
    step();
    set_in(2'b01, 4'h0, 1'b1);
    check("t2_ld_mem", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,1,0,1,0,2'd0,4'h0,1,0)));
    step();
    set_in(2'b01, 4'h0, 1'b0);
    check("t2_ld_wb", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,1,2'd1,4'h0,0,0)));
    step();
    check("t2_ld_retired", retired, 32'd1);
    fetch("t2_st", 2'b01, 4'h1);
    check("t2_st_exec", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,0,2'd0,4'h0,1,0)));
    step();
    set_in(2'b01, 4'h1, 1'b1);
    check("t2_st_mem", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,1,1,1,0,2'd0,4'h0,1,0)));
    step();
    set_in(2'b01, 4'h1, 1'b0);
    check("t2_st_back_fetch", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,1,0,0,0,2'd0,4'h0,0,0)));
    check("t2_retired", retired, 32'd2);

    // 3: BZ taken / not taken, BL, JR
    do_reset();
    go();
    flag_z = 1'b1;
    fetch("t3_bz_t", 2'b01, 4'h2);
    check("t3_bz_taken", 32'(obs_ctl()), 32'(ctl(0,1,2'd1,0,0,0,0,2'd0,4'h0,0,0)));
    step();
    flag_z = 1'b0;
    fetch("t3_bz_n", 2'b01, 4'h2);
    check("t3_bz_not_taken", 32'(obs_ctl()), 32'(ctl(0,0,2'd1,0,0,0,0,2'd0,4'h0,0,0)));
    step();
    fetch("t3_bl", 2'b10, 4'h1);
    check("t3_bl_exec", 32'(obs_ctl()), 32'(ctl(0,1,2'd2,0,0,0,1,2'd2,4'h0,0,0)));
    step();
    fetch("t3_jr", 2'b10, 4'h2);
    check("t3_jr_exec", 32'(obs_ctl()), 32'(ctl(0,1,2'd3,0,0,0,0,2'd0,4'h0,0,0)));
    step();
    check("t3_retired", retired, 32'd4);

    // 4: illegal encoding -> FAULT, start ignored, rst recovers
    do_reset();
    go();
    set_in(2'b11, 4'h7, 1'b1);
    step();
    set_in(2'b11, 4'h7, 1'b0);
    check("t4_decode_illegal_pre", 32'(illegal), 32'd0);
    step();
    check("t4_illegal", 32'(illegal), 32'd1);
    check("t4_fault_ctl", 32'(obs_ctl()), 32'h0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    #1;
    check("t4_start_ignored", 32'(obs_ctl()), 32'h0);
    check("t4_retired", retired, 32'd0);
    do_reset();
    check("t4_rst_illegal", 32'(illegal), 32'd0);
    check("t4_rst_ctl", 32'(obs_ctl()), 32'h0);
    go();
    set_in(2'b00, 4'h0, 1'b0);
    check("t4_idle_to_fetch", 32'(bus.mem_req), 32'd1);

    // 5: fetch timeout at 4 request cycles, then ack on exactly cycle 4
    do_reset();
    go();
    set_in(2'b00, 4'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t5_req_c%0d", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("t5_bus_err_c%0d", i), 32'(bus_err), 32'd0);
      step();
    end
    check("t5_timeout_bus_err", 32'(bus_err), 32'd1);
    check("t5_timeout_ctl", 32'(obs_ctl()), 32'h0);
    do_reset();
    go();
    set_in(2'b00, 4'h0, 1'b0);
    step();
    step();
    step();
    set_in(2'b00, 4'h0, 1'b1);
    check("t5_ack4_ctl", 32'(obs_ctl()), 32'(ctl(1,1,2'd0,1,0,0,0,2'd0,4'h0,0,0)));
    step();
    set_in(2'b00, 4'h0, 1'b0);
    check("t5_ack4_no_bus_err", 32'(bus_err), 32'd0);
    check("t5_ack4_decode", 32'(obs_ctl()), 32'h0);

    // 6: two NOPs then HALT; then rst in the middle of a MEM request
    do_reset();
    go();
    fetch("t6_nop1", 2'b11, 4'h0);
    check("t6_nop1_exec", 32'(obs_ctl()), 32'h0);
    step();
    fetch("t6_nop2", 2'b11, 4'h0);
    step();
    fetch("t6_halt", 2'b11, 4'h1);
    check("t6_halt_exec", 32'(obs_ctl()), 32'h0);
    step();
    check("t6_halted", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,0,2'd0,4'h0,0,1)));
    check("t6_retired", retired, 32'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("t6_halt_start_ignored", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,0,0,0,0,2'd0,4'h0,0,1)));
    do_reset();
    go();
    fetch("t6_nop3", 2'b11, 4'h0);
    step();
    fetch("t6_ld", 2'b01, 4'h0);
    step();
    set_in(2'b01, 4'h0, 1'b0);
    check("t6_mid_mem", 32'(obs_ctl()), 32'(ctl(0,0,2'd0,1,0,1,0,2'd0,4'h0,1,0)));
    check("t6_mid_retired", retired, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_rst_mem_ctl", 32'(obs_ctl()), 32'h0);
    check("t6_rst_retired", retired, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
